// File: rtl/hilbert_envelope_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hilbert_pkg
//  Purpose  : Shared constants for the hilbert envelope slice: default frame
//             geometry, FSM state encoding and the beta shift amounts used by
//             the alpha-max-plus-beta-min magnitude approximation.
//  Contents : c_TOTAL_BITS, c_N, c_AW     - default sample width / frame size
//             c_ST_IDLE/CAPTURE/DRAIN     - 2-bit FSM encoding
//             c_BETA_SH1/c_BETA_SH2       - beta = 1/4 + 1/8 = 3/8
//  Revision : 1.0 - initial release
// ============================================================================
package hilbert_pkg;

    // Default frame geometry (matches the 32-point hilbert stage)
    localparam int c_TOTAL_BITS = 32;
    localparam int c_N          = 32;
    localparam int c_AW         = 5;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;

    // beta = 3/8 realised as (mn >> 2) + (mn >> 3)
    localparam int c_BETA_SH1 = 2;
    localparam int c_BETA_SH2 = 3;

endpackage : hilbert_pkg
`default_nettype wire

// File: rtl/hilbert_envelope_env_mag.sv
`default_nettype none
// ============================================================================
//  Module   : env_mag
//  Purpose  : Two-stage envelope magnitude pipeline.
//             Stage 1 registers |re| and |im| (total_bits-1 bits, the most
//             negative input saturates to the largest positive value).
//             Stage 2 registers mag = max + (min>>2) + (min>>3).
//             Both stages, including their valid bits, advance only when
//             i_ed is high.
//  Ports    : CLK      - clock, rising edge
//             RST      - asynchronous active-high reset
//             i_ed     - pipeline advance enable
//             i_valid  - the sample on i_re/i_im is part of the frame
//             i_re     - signed real input
//             i_im     - signed imaginary input
//             o_valid  - o_mag holds a frame sample
//             o_mag    - unsigned magnitude estimate
//  Revision : 1.0 - initial release
// ============================================================================
module env_mag
    import hilbert_pkg::*;
#(
    parameter int total_bits = c_TOTAL_BITS
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_ed,
    input  logic                  i_valid,
    input  logic [total_bits-1:0] i_re,
    input  logic [total_bits-1:0] i_im,
    output logic                  o_valid,
    output logic [total_bits-1:0] o_mag
);

    // Saturating absolute value into total_bits-1 bits. For a negative
    // operand other than the most negative one, the low bits of the two's
    // complement negation are exactly ~x + 1 over the low bits.
    function automatic logic [total_bits-2:0] sat_abs(input logic [total_bits-1:0] x);
        if (!x[total_bits-1]) begin
            sat_abs = x[total_bits-2:0];
        end else if (x[total_bits-2:0] == '0) begin
            sat_abs = {(total_bits-1){1'b1}};
        end else begin
            sat_abs = (~x[total_bits-2:0]) + {{(total_bits-2){1'b0}}, 1'b1};
        end
    endfunction

    logic [total_bits-2:0] r_ar;
    logic [total_bits-2:0] r_ai;
    logic                  r_v1;
    logic [total_bits-1:0] r_mag;
    logic                  r_v2;

    logic [total_bits-2:0] w_mx;
    logic [total_bits-2:0] w_mn;
    logic [total_bits-1:0] w_sum;

    assign w_mx = (r_ar >= r_ai) ? r_ar : r_ai;
    assign w_mn = (r_ar >= r_ai) ? r_ai : r_ar;

    // 1.375 * (2^(total_bits-1) - 1) always fits in total_bits unsigned
    assign w_sum = {1'b0, w_mx}
                 + {1'b0, (w_mn >> c_BETA_SH1)}
                 + {1'b0, (w_mn >> c_BETA_SH2)};

    // Stage 1: absolute values
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ar <= '0;
            r_ai <= '0;
            r_v1 <= 1'b0;
        end else if (i_ed) begin
            r_ar <= sat_abs(i_re);
            r_ai <= sat_abs(i_im);
            r_v1 <= i_valid;
        end
    end

    // Stage 2: max/min combine
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mag <= '0;
            r_v2  <= 1'b0;
        end else if (i_ed) begin
            r_mag <= w_sum;
            r_v2  <= r_v1;
        end
    end

    assign o_valid = r_v2;
    assign o_mag   = r_mag;

endmodule : env_mag
`default_nettype wire

// File: rtl/hilbert_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : hilbert_envelope
//  Purpose  : Captures one N-sample analytic-signal frame from the hilbert
//             stage after each RDY rise, converts every sample to an envelope
//             magnitude (alpha = 1, beta = 3/8), buffers the frame and then
//             streams it out over a valid/ready handshake.
//  Ports    : CLK        - clock, rising edge
//             RST        - asynchronous active-high reset
//             ED         - data strobe; qualifies capture cycles
//             RDY        - frame-ready from the hilbert stage
//             DOReal     - signed real sample
//             DOImag     - signed imaginary sample
//             ENV_DATA   - unsigned envelope sample
//             ENV_ADDR   - index of ENV_DATA within the frame
//             ENV_VALID  - ENV_DATA is valid
//             ENV_LAST   - final sample of the frame
//             ENV_READY  - downstream accepts the sample
//             BUSY       - frame in capture or drain
//             OVF        - sticky: a frame was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module hilbert_envelope
    import hilbert_pkg::*;
#(
    parameter int total_bits = c_TOTAL_BITS,
    parameter int N          = c_N,
    parameter int AW         = c_AW
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ED,
    input  logic                  RDY,
    input  logic [total_bits-1:0] DOReal,
    input  logic [total_bits-1:0] DOImag,
    output logic [total_bits-1:0] ENV_DATA,
    output logic [AW-1:0]         ENV_ADDR,
    output logic                  ENV_VALID,
    output logic                  ENV_LAST,
    input  logic                  ENV_READY,
    output logic                  BUSY,
    output logic                  OVF
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(N - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic                  r_rdy_q;
    logic                  w_rdy_rise;

    logic [AW-1:0]         r_cap_cnt;     // samples accepted so far
    logic                  r_cap_done;    // all N samples accepted
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  r_ovf;

    logic                  w_in_capture;
    logic                  w_pipe_in_valid;
    logic                  w_mag_valid;
    logic [total_bits-1:0] w_mag;
    logic                  w_wr_en;
    logic                  w_wr_last;
    logic                  w_env_valid;
    logic                  w_xfer;
    logic                  w_xfer_last;

    logic [total_bits-1:0] r_buf [N];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_rdy_rise      = RDY & ~r_rdy_q;
    assign w_in_capture    = (r_state == c_ST_CAPTURE);

    // Once N samples are in, further ED strobes push bubbles only
    assign w_pipe_in_valid = w_in_capture & ~r_cap_done;

    // The pipeline output is meaningful only on an ED edge
    assign w_wr_en         = ED & w_mag_valid & w_in_capture;
    assign w_wr_last       = w_wr_en & (r_wr_ptr == c_LAST_IDX);

    assign w_xfer          = w_env_valid & ENV_READY;
    assign w_xfer_last     = w_xfer & (r_rd_ptr == c_LAST_IDX);

    // ------------------------------------------------------------------
    // Magnitude pipeline
    // ------------------------------------------------------------------
    env_mag #(
        .total_bits (total_bits)
    ) u_env_mag (
        .CLK     (CLK),
        .RST     (RST),
        .i_ed    (ED),
        .i_valid (w_pipe_in_valid),
        .i_re    (DOReal),
        .i_im    (DOImag),
        .o_valid (w_mag_valid),
        .o_mag   (w_mag)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rdy_rise) begin
                    w_state_nxt = c_ST_CAPTURE;
                end
            end
            c_ST_CAPTURE: begin
                if (w_wr_last) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_xfer_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_env_valid = (r_state == c_ST_DRAIN);
        BUSY        = (r_state != c_ST_IDLE);
        ENV_VALID   = w_env_valid;
        ENV_LAST    = w_env_valid & (r_rd_ptr == c_LAST_IDX);
        ENV_ADDR    = r_rd_ptr;
        // Gate the buffer read so the output reads zero outside DRAIN
        // (the buffer itself is never reset)
        ENV_DATA    = w_env_valid ? r_buf[r_rd_ptr] : '0;
        OVF         = r_ovf;
    end

    // ------------------------------------------------------------------
    // RDY edge detector, counters and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rdy_q    <= 1'b0;
            r_cap_cnt  <= '0;
            r_cap_done <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_rdy_q <= RDY;

            // A rise while a frame is in flight (including the very edge on
            // which DRAIN hands back to IDLE) drops the new frame
            if (w_rdy_rise && (r_state != c_ST_IDLE)) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_rdy_rise) begin
                        r_cap_cnt  <= '0;
                        r_cap_done <= 1'b0;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                    end
                end
                c_ST_CAPTURE: begin
                    if (ED && !r_cap_done) begin
                        if (r_cap_cnt == c_LAST_IDX) begin
                            r_cap_cnt  <= '0;
                            r_cap_done <= 1'b1;
                        end else begin
                            r_cap_cnt  <= r_cap_cnt + AW'(1);
                        end
                    end
                    if (w_wr_en) begin
                        r_wr_ptr <= (r_wr_ptr == c_LAST_IDX) ? '0 : r_wr_ptr + AW'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (w_xfer) begin
                        r_rd_ptr <= (r_rd_ptr == c_LAST_IDX) ? '0 : r_rd_ptr + AW'(1);
                    end
                end
                default: begin
                    r_cap_done <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer (contents are don't-care after reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr] <= w_mag;
        end
    end

endmodule : hilbert_envelope
`default_nettype wire

// File: tb/tb_hilbert_envelope.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hilbert_envelope
//  Purpose  : Directed self-checking bench for hilbert_envelope.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilbert_envelope;

    localparam int W   = 32;
    localparam int NS  = 32;
    localparam int AWL = 5;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           ED  = 1'b0;
    logic           RDY = 1'b0;
    logic           ENV_READY = 1'b0;
    logic [W-1:0]   DOReal = '0;
    logic [W-1:0]   DOImag = '0;
    logic [W-1:0]   ENV_DATA;
    logic [AWL-1:0] ENV_ADDR;
    logic           ENV_VALID;
    logic           ENV_LAST;
    logic           BUSY;
    logic           OVF;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fr_re [NS];
    logic [W-1:0] fr_im [NS];
    logic [W-1:0] exp_d [NS];

    always #5 CLK = ~CLK;

    hilbert_envelope #(
        .total_bits (W),
        .N          (NS),
        .AW         (AWL)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ED        (ED),
        .RDY       (RDY),
        .DOReal    (DOReal),
        .DOImag    (DOImag),
        .ENV_DATA  (ENV_DATA),
        .ENV_ADDR  (ENV_ADDR),
        .ENV_VALID (ENV_VALID),
        .ENV_LAST  (ENV_LAST),
        .ENV_READY (ENV_READY),
        .BUSY      (BUSY),
        .OVF       (OVF)
    );

    // Reference envelope: saturated |x|, then max + floor(min/4) + floor(min/8)
    function automatic logic [W-1:0] env_model(input logic [W-1:0] re, input logic [W-1:0] im);
        longint a, b, mx, mn;
        a = longint'($signed(re));
        b = longint'($signed(im));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
        if (b > 64'sh7FFF_FFFF) b = 64'sh7FFF_FFFF;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return W'(mx + mn / 4 + mn / 8);
    endfunction

    // Pulse RDY, then present the frame on ED=1 cycles until ENV_VALID rises.
    // With abort_at >= 0 it returns once that many samples were accepted.
    task automatic capture_frame(input bit toggle_ed, input int abort_at, input string tag);
        int idx = 0;
        int cyc = 0;
        bit ed_now = 1'b1;
        RDY    = 1'b1;
        ED     = 1'b1;
        DOReal = 32'h1234_5678;   // must not be captured: FSM is still IDLE
        DOImag = 32'hEDCB_A987;
        @(posedge CLK); #1;
        RDY = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_on_capture: got %b want 1", tag, BUSY);
        end
        while (!ENV_VALID && cyc < 400 && !(abort_at >= 0 && idx >= abort_at)) begin
            ED = ed_now;
            if (ed_now && idx < NS) begin
                DOReal = fr_re[idx];
                DOImag = fr_im[idx];
            end else begin
                DOReal = 32'h5A5A_0000 + 32'(cyc);
                DOImag = 32'hA5A5_0000 - 32'(cyc);
            end
            @(posedge CLK); #1;
            if (ed_now) idx++;
            if (toggle_ed) ed_now = !ed_now;
            cyc++;
        end
        ED = 1'b0;
        if (abort_at < 0) begin
            checks++;
            if (ENV_VALID !== 1'b1) begin
                errors++;
                $display("FAIL %s_capture_timeout: ENV_VALID=%b after %0d cycles, want 1", tag, ENV_VALID, cyc);
            end
        end
    endtask

    // mode 0: ENV_READY=1 always; 1: stall 5 cycles at index 7 then random;
    // 2: ENV_READY=1 and a new RDY rise at index 3
    task automatic drain_frame(input int mode, input string tag);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        bit rd;
        while (k < NS && cyc < 2000) begin
            if (mode == 1) begin
                if (k == 7 && stall < 5) begin
                    rd = 1'b0;
                    stall++;
                end else begin
                    rd = ($urandom_range(0, 1) != 0);
                end
            end else begin
                rd = 1'b1;
            end
            ENV_READY = rd;
            RDY = (mode == 2 && k == 3);
            checks++;
            if (ENV_VALID !== 1'b1 || ENV_ADDR !== AWL'(k) || ENV_DATA !== exp_d[k] ||
                ENV_LAST !== (k == NS - 1)) begin
                errors++;
                $display("FAIL %s_out[%0d]: got valid=%b addr=%0d data=%08h last=%b want valid=1 addr=%0d data=%08h last=%b",
                         tag, k, ENV_VALID, ENV_ADDR, ENV_DATA, ENV_LAST, k, exp_d[k], (k == NS - 1));
            end
            @(posedge CLK); #1;
            cyc++;
            if (rd) k++;
        end
        ENV_READY = 1'b0;
        RDY = 1'b0;
        checks++;
        if (k != NS) begin
            errors++;
            $display("FAIL %s_drain_count: got %0d transfers want %0d", tag, k, NS);
        end
        checks++;
        if (ENV_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_after_drain: got valid=%b busy=%b want 0 0", tag, ENV_VALID, BUSY);
        end
        if (mode == 0) begin
            checks++;
            if (cyc != NS) begin
                errors++;
                $display("FAIL %s_back_to_back: got %0d cycles want %0d", tag, cyc, NS);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (ENV_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ENV_VALID); end
        checks++;
        if (ENV_LAST !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", ENV_LAST); end
        checks++;
        if (ENV_ADDR !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ENV_ADDR); end
        checks++;
        if (ENV_DATA !== '0) begin errors++; $display("FAIL reset_data: got %08h want 0", ENV_DATA); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++;
        if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", OVF); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'd300;
            fr_im[k] = 32'd400;
            exp_d[k] = 32'd512;
        end
        capture_frame(1'b0, -1, "basic");
        drain_frame(0, "basic");
        checks++;
        if (OVF !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", OVF); end
    endtask

    task automatic test_corners();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'(k * 1000);
            fr_im[k] = 32'(-(k * 7));
            exp_d[k] = env_model(fr_re[k], fr_im[k]);
        end
        fr_re[0] = 32'hFFFF_FC18; fr_im[0] = 32'd0;          exp_d[0] = 32'd1000;
        fr_re[1] = 32'hFFFF_FFF8; fr_im[1] = 32'd8;          exp_d[1] = 32'd11;
        fr_re[2] = 32'h8000_0000; fr_im[2] = 32'd0;          exp_d[2] = 32'h7FFF_FFFF;
        fr_re[3] = 32'd0;         fr_im[3] = 32'd0;          exp_d[3] = 32'd0;
        capture_frame(1'b0, -1, "corners");
        drain_frame(0, "corners");
    endtask

    task automatic test_ed_toggle();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'(k);
            fr_im[k] = 32'd0;
            exp_d[k] = 32'(k);
        end
        capture_frame(1'b1, -1, "ed_toggle");
        drain_frame(0, "ed_toggle");
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'(k * 12345);
            fr_im[k] = 32'(-(k * 54321));
            exp_d[k] = env_model(fr_re[k], fr_im[k]);
        end
        capture_frame(1'b0, -1, "backpressure");
        drain_frame(1, "backpressure");
    endtask

    task automatic test_overflow();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'(5 * k);
            fr_im[k] = 32'(3 * k);
            exp_d[k] = env_model(fr_re[k], fr_im[k]);
        end
        capture_frame(1'b0, -1, "ovf_frame");
        drain_frame(2, "ovf_frame");
        checks++;
        if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", OVF); end
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'(-((k + 1) * 3));
            fr_im[k] = 32'(k * k);
            exp_d[k] = env_model(fr_re[k], fr_im[k]);
        end
        capture_frame(1'b0, -1, "ovf_next");
        drain_frame(0, "ovf_next");
        checks++;
        if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", OVF); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'd7777;
            fr_im[k] = 32'd0;
        end
        capture_frame(1'b0, 10, "rst_mid");
        RST = 1'b1;
        #2;
        checks++;
        if (ENV_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got valid=%b busy=%b want 0 0", ENV_VALID, BUSY);
        end
        checks++;
        if (OVF !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b want 0", OVF); end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (ENV_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_released: got valid=%b busy=%b want 0 0", ENV_VALID, BUSY);
        end
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'(100 + k);
            fr_im[k] = 32'(-(2 * k));
            exp_d[k] = env_model(fr_re[k], fr_im[k]);
        end
        capture_frame(1'b0, -1, "after_rst");
        drain_frame(0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ed_toggle();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hilbert_envelope
`default_nettype wire
